// File: rtl/ft600_device_model.sv
// Chip-side FT600 245 synchronous FIFO model: RX buffer (host->FPGA) and TX buffer (FPGA->host).
// Flags are registered with one edge of latency; host_tx_ready and host_rx_valid are combinational from the counts.
module ft600_device_model #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ftdi_rxf_n,
  output logic        ftdi_txe_n,
  input  logic        ftdi_oe_n,
  input  logic        ftdi_rd_n,
  input  logic        ftdi_wr_n,
  input  logic [15:0] ftdi_data_i,
  input  logic [1:0]  ftdi_be_i,
  output logic [15:0] ftdi_data_o,
  output logic [1:0]  ftdi_be_o,
  output logic        ftdi_data_oe,
  input  logic        host_tx_valid,
  input  logic [15:0] host_tx_data,
  input  logic [1:0]  host_tx_be,
  output logic        host_tx_ready,
  output logic        host_rx_valid,
  output logic [15:0] host_rx_data,
  output logic [1:0]  host_rx_be,
  input  logic        host_rx_ready,
  output logic        err_rd_underflow,
  output logic        err_wr_overflow,
  output logic        err_rd_no_oe
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [17:0]   rx_mem_q [DEPTH];
  logic [17:0]   tx_mem_q [DEPTH];
  logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic          rxf_n_q, rxf_n_d, txe_n_q, txe_n_d, data_oe_q, data_oe_d;
  logic          err_uf_q, err_uf_d, err_ov_q, err_ov_d, err_noe_q, err_noe_d;
  logic          rx_push, rx_pop, tx_push, tx_pop;
  logic          rx_empty, tx_empty;
  logic [17:0]   rx_head, tx_head;

  assign rx_empty = (rx_cnt_q == '0);
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_head  = rx_mem_q[rx_rp_q];
  assign tx_head  = tx_mem_q[tx_rp_q];

  always_comb begin
    // A full buffer refuses a push even when a pop frees a slot at the same edge.
    rx_push = host_tx_valid && (rx_cnt_q != FULL);
    rx_pop  = !ftdi_rd_n && !ftdi_oe_n && !rx_empty;
    tx_push = !ftdi_wr_n && !txe_n_q;
    tx_pop  = host_rx_ready && !tx_empty;

    rx_wp_d  = rx_push ? rx_wp_q + 1'b1 : rx_wp_q;
    rx_rp_d  = rx_pop  ? rx_rp_q + 1'b1 : rx_rp_q;
    rx_cnt_d = rx_cnt_q + {{(CW-1){1'b0}}, rx_push} - {{(CW-1){1'b0}}, rx_pop};
    tx_wp_d  = tx_push ? tx_wp_q + 1'b1 : tx_wp_q;
    tx_rp_d  = tx_pop  ? tx_rp_q + 1'b1 : tx_rp_q;
    tx_cnt_d = tx_cnt_q + {{(CW-1){1'b0}}, tx_push} - {{(CW-1){1'b0}}, tx_pop};

    rxf_n_d   = (rx_cnt_d == '0);
    txe_n_d   = (tx_cnt_d == FULL);
    data_oe_d = !ftdi_oe_n;

    err_uf_d  = err_uf_q  | (!ftdi_rd_n && !ftdi_oe_n && rx_empty);
    err_ov_d  = err_ov_q  | (!ftdi_wr_n && txe_n_q);
    err_noe_d = err_noe_q | (!ftdi_rd_n && ftdi_oe_n);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
      rx_cnt_q  <= '0;
      tx_wp_q   <= '0;
      tx_rp_q   <= '0;
      tx_cnt_q  <= '0;
      rxf_n_q   <= 1'b1;
      txe_n_q   <= 1'b1;
      data_oe_q <= 1'b0;
      err_uf_q  <= 1'b0;
      err_ov_q  <= 1'b0;
      err_noe_q <= 1'b0;
    end else begin
      rx_wp_q   <= rx_wp_d;
      rx_rp_q   <= rx_rp_d;
      rx_cnt_q  <= rx_cnt_d;
      tx_wp_q   <= tx_wp_d;
      tx_rp_q   <= tx_rp_d;
      tx_cnt_q  <= tx_cnt_d;
      rxf_n_q   <= rxf_n_d;
      txe_n_q   <= txe_n_d;
      data_oe_q <= data_oe_d;
      err_uf_q  <= err_uf_d;
      err_ov_q  <= err_ov_d;
      err_noe_q <= err_noe_d;
    end
  end

  // Storage needs no reset: the counts alone decide what is valid.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wp_q] <= {host_tx_be, host_tx_data};
    if (tx_push) tx_mem_q[tx_wp_q] <= {ftdi_be_i, ftdi_data_i};
  end

  assign ftdi_rxf_n       = rxf_n_q;
  assign ftdi_txe_n       = txe_n_q;
  assign ftdi_data_oe     = data_oe_q;
  assign ftdi_data_o      = rx_empty ? 16'h0000 : rx_head[15:0];
  assign ftdi_be_o        = rx_empty ? 2'b00 : rx_head[17:16];
  assign host_tx_ready    = (rx_cnt_q != FULL);
  assign host_rx_valid    = !tx_empty;
  assign host_rx_data     = tx_head[15:0];
  assign host_rx_be       = tx_head[17:16];
  assign err_rd_underflow = err_uf_q;
  assign err_wr_overflow  = err_ov_q;
  assign err_rd_no_oe     = err_noe_q;

endmodule
